// File: rtl/iocntl_pkg.sv
// Shared types and constants for the DRAM I/O read arbiter.
package iocntl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam int TIMEOUT_DEFAULT = 64;
    localparam int ADDR_W          = 28;
    localparam int WORD_W          = 16;
    localparam int WORDS           = 8;
    localparam int DATA_W          = WORD_W * WORDS;

endpackage : iocntl_pkg

// File: rtl/iocntl_arb_rr_pick.sv
// Combinational round-robin picker: rotate requests so the search starts
// just after last_owner, isolate the lowest set bit, rotate back.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N-1:0]     gnt,
    output logic             any
);

    logic [IDX_W-1:0] start_s;
    logic [2*N-1:0]   dbl_req_s;
    logic [2*N-1:0]   dbl_gnt_s;
    logic [N-1:0]     rot_req_s;
    logic [N-1:0]     rot_gnt_s;

    // Rotate, pick lowest requester in rotated order, rotate the winner back.
    always_comb begin
        start_s   = (last_owner == IDX_W'(N - 1)) ? {IDX_W{1'b0}} : last_owner + IDX_W'(1);
        dbl_req_s = {req, req} >> start_s;
        rot_req_s = dbl_req_s[N-1:0];
        rot_gnt_s = rot_req_s & (~rot_req_s + N'(1));
        dbl_gnt_s = {rot_gnt_s, rot_gnt_s} << start_s;
        gnt       = dbl_gnt_s[2*N-1:N];
        any       = |req;
    end

endmodule : rr_pick

// File: rtl/iocntl_arb.sv
// Round-robin read arbiter: funnels NUM_CLIENTS requesters onto a single
// DRAM I/O controller read port, one read outstanding at a time, with timeout.
module iocntl_arb
    import iocntl_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        cli_req,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
    output logic [NUM_CLIENTS-1:0]        cli_gnt,
    output logic [NUM_CLIENTS-1:0]        cli_valid,
    output logic [NUM_CLIENTS-1:0]        cli_err,
    output logic [DATA_W-1:0]             cli_data,
    output logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_req,
    input  logic                          rd_gnt,
    input  logic                          rd_valid,
    input  logic [DATA_W-1:0]             rd_data,
    output logic                          stray
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e               state_r, state_s;
    logic [IDX_W-1:0]         last_owner_r, last_owner_s;
    logic [CNT_W-1:0]         cnt_r, cnt_s;
    logic                     rd_req_r, rd_req_s;
    logic [ADDR_W-1:0]        rd_addr_r, rd_addr_s;
    logic [NUM_CLIENTS-1:0]   cli_gnt_r, cli_gnt_s;
    logic [NUM_CLIENTS-1:0]   cli_valid_r, cli_valid_s;
    logic [NUM_CLIENTS-1:0]   cli_err_r, cli_err_s;
    logic                     stray_r, stray_s;
    logic [DATA_W-1:0]        cli_data_r, cli_data_s;

    logic [NUM_CLIENTS-1:0]   pick_s;
    logic                     pick_any_s;
    logic [IDX_W-1:0]         pick_idx_s;
    logic [ADDR_W-1:0]        pick_addr_s;
    logic [NUM_CLIENTS-1:0]   owner_onehot_s;
    logic [CNT_W-1:0]         cnt_inc_s;
    logic                     timeout_hit_s;

    rr_pick #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (cli_req),
        .last_owner (last_owner_r),
        .gnt        (pick_s),
        .any        (pick_any_s)
    );

    // Winner index/address decode and timeout compare.
    always_comb begin
        pick_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            pick_idx_s = pick_idx_s | (pick_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        pick_addr_s    = cli_addr[ADDR_W*int'(pick_idx_s) +: ADDR_W];
        owner_onehot_s = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << last_owner_r;
        cnt_inc_s      = cnt_r + CNT_W'(1);
        timeout_hit_s  = (cnt_inc_s == CNT_W'(TIMEOUT));
    end

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_s      = state_r;
        last_owner_s = last_owner_r;
        cnt_s        = cnt_r;
        rd_req_s     = rd_req_r;
        rd_addr_s    = rd_addr_r;
        cli_gnt_s    = {NUM_CLIENTS{1'b0}};
        cli_valid_s  = {NUM_CLIENTS{1'b0}};
        cli_err_s    = {NUM_CLIENTS{1'b0}};
        stray_s      = 1'b0;
        cli_data_s   = cli_data_r;

        case (state_r)
            ST_IDLE: begin
                stray_s = rd_valid;
                if (pick_any_s) begin
                    state_s      = ST_ISSUE;
                    last_owner_s = pick_idx_s;
                    cli_gnt_s    = pick_s;
                    rd_req_s     = 1'b1;
                    rd_addr_s    = pick_addr_s;
                    cnt_s        = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_s = cnt_inc_s;
                if (rd_gnt && rd_valid) begin
                    state_s     = ST_IDLE;
                    rd_req_s    = 1'b0;
                    cli_data_s  = rd_data;
                    cli_valid_s = owner_onehot_s;
                end else if (timeout_hit_s) begin
                    state_s   = ST_IDLE;
                    rd_req_s  = 1'b0;
                    cli_err_s = owner_onehot_s;
                end else if (rd_gnt) begin
                    state_s  = ST_WAIT;
                    rd_req_s = 1'b0;
                end else begin
                    // A response before the controller accepted anything is unowned.
                    stray_s = rd_valid;
                end
            end
            ST_WAIT: begin
                cnt_s = cnt_inc_s;
                if (rd_valid) begin
                    state_s     = ST_IDLE;
                    cli_data_s  = rd_data;
                    cli_valid_s = owner_onehot_s;
                end else if (timeout_hit_s) begin
                    state_s   = ST_IDLE;
                    rd_req_s  = 1'b0;
                    cli_err_s = owner_onehot_s;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                rd_req_s = 1'b0;
            end
        endcase
    end

    // State and registered-output bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_owner_r <= IDX_W'(NUM_CLIENTS - 1);
            cnt_r        <= {CNT_W{1'b0}};
            rd_req_r     <= 1'b0;
            rd_addr_r    <= {ADDR_W{1'b0}};
            cli_gnt_r    <= {NUM_CLIENTS{1'b0}};
            cli_valid_r  <= {NUM_CLIENTS{1'b0}};
            cli_err_r    <= {NUM_CLIENTS{1'b0}};
            stray_r      <= 1'b0;
            cli_data_r   <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_s;
            last_owner_r <= last_owner_s;
            cnt_r        <= cnt_s;
            rd_req_r     <= rd_req_s;
            rd_addr_r    <= rd_addr_s;
            cli_gnt_r    <= cli_gnt_s;
            cli_valid_r  <= cli_valid_s;
            cli_err_r    <= cli_err_s;
            stray_r      <= stray_s;
            cli_data_r   <= cli_data_s;
        end
    end

    assign cli_gnt   = cli_gnt_r;
    assign cli_valid = cli_valid_r;
    assign cli_err   = cli_err_r;
    assign cli_data  = cli_data_r;
    assign rd_addr   = rd_addr_r;
    assign rd_req    = rd_req_r;
    assign stray     = stray_r;

endmodule : iocntl_arb

// File: tb/tb_iocntl_arb.sv
// Directed self-checking bench for iocntl_arb (4 clients, TIMEOUT 64).
module tb_iocntl_arb;

    localparam logic [127:0] EXP_A = 128'hA007_A006_A005_A004_A003_A002_A001_A000;
    localparam logic [127:0] JUNK  = 128'h5555_5555_5555_5555_5555_5555_5555_5555;

    logic         clock;
    logic         reset;
    logic [3:0]   cli_req;
    logic [111:0] cli_addr;
    logic [3:0]   cli_gnt;
    logic [3:0]   cli_valid;
    logic [3:0]   cli_err;
    logic [127:0] cli_data;
    logic [27:0]  rd_addr;
    logic         rd_req;
    logic         rd_gnt;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic         stray;

    int           n_cmp;
    int           n_mis;
    logic [3:0]   exp_gnt;
    logic [127:0] exp_data;
    logic         seen_s;

    iocntl_arb #(
        .NUM_CLIENTS (4),
        .TIMEOUT     (64)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cli_req   (cli_req),
        .cli_addr  (cli_addr),
        .cli_gnt   (cli_gnt),
        .cli_valid (cli_valid),
        .cli_err   (cli_err),
        .cli_data  (cli_data),
        .rd_addr   (rd_addr),
        .rd_req    (rd_req),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .stray     (stray)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        reset    = 1'b1;
        cli_req  = 4'b0000;
        cli_addr = 112'h0;
        rd_gnt   = 1'b0;
        rd_valid = 1'b0;
        rd_data  = 128'h0;
        for (int k = 0; k < 4; k++) cli_addr[k*28 +: 28] = 28'h0F00000 | 28'(k);

        // Reset state
        tick();
        tick();
        chk("rst_rd_req",    rd_req,    1'b0);
        chk("rst_rd_addr",   rd_addr,   28'h0);
        chk("rst_cli_gnt",   cli_gnt,   4'b0000);
        chk("rst_cli_valid", cli_valid, 4'b0000);
        chk("rst_cli_err",   cli_err,   4'b0000);
        chk("rst_stray",     stray,     1'b0);
        chk("rst_cli_data",  cli_data,  128'h0);
        reset = 1'b0;
        tick();
        chk("idle_rd_req", rd_req, 1'b0);

        // Fairness: all four held, grant/response turned around immediately
        cli_req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_gnt  = 4'b0001 << (k % 4);
            exp_data = 128'h1111_0000 + 128'(k);
            chk("fair_gnt",     cli_gnt, exp_gnt);
            chk("fair_rd_req",  rd_req,  1'b1);
            chk("fair_rd_addr", rd_addr, 28'h0F00000 | 28'(k % 4));
            tick();
            chk("fair_gnt_pulse", cli_gnt, 4'b0000);
            chk("fair_rd_hold",   rd_req,  1'b1);
            rd_gnt   = 1'b1;
            rd_valid = 1'b1;
            rd_data  = exp_data;
            tick();
            chk("fair_valid",   cli_valid, exp_gnt);
            chk("fair_data",    cli_data,  exp_data);
            chk("fair_rd_drop", rd_req,    1'b0);
            chk("fair_no_gnt",  cli_gnt,   4'b0000);
            rd_gnt   = 1'b0;
            rd_valid = 1'b0;
            if (k == 4) cli_req = 4'b0000;
            tick();
        end
        chk("fair_end_gnt",    cli_gnt, 4'b0000);
        chk("fair_end_rd_req", rd_req,  1'b0);

        // Single request from client 2
        cli_addr[2*28 +: 28] = 28'h0012345;
        cli_req = 4'b0100;
        tick();
        chk("single_gnt",     cli_gnt, 4'b0100);
        chk("single_rd_req",  rd_req,  1'b1);
        chk("single_rd_addr", rd_addr, 28'h0012345);
        cli_req = 4'b0000;
        tick();
        chk("single_gnt_pulse", cli_gnt, 4'b0000);
        rd_gnt = 1'b1;
        tick();
        chk("single_rd_drop",  rd_req,    1'b0);
        chk("single_no_valid", cli_valid, 4'b0000);
        rd_gnt   = 1'b0;
        rd_valid = 1'b1;
        rd_data  = EXP_A;
        tick();
        chk("single_valid",     cli_valid, 4'b0100);
        chk("single_data",      cli_data,  EXP_A);
        chk("single_addr_hold", rd_addr,   28'h0012345);
        rd_valid = 1'b0;
        tick();
        chk("single_valid_pulse", cli_valid, 4'b0000);

        // Stray response while idle
        rd_valid = 1'b1;
        rd_data  = JUNK;
        tick();
        chk("stray_pulse",    stray,     1'b1);
        chk("stray_no_valid", cli_valid, 4'b0000);
        chk("stray_data",     cli_data,  EXP_A);
        rd_valid = 1'b0;
        tick();
        chk("stray_clear", stray,    1'b0);
        chk("stray_data2", cli_data, EXP_A);

        // Timeout: client 1 granted, controller accepts but never responds
        cli_req = 4'b0010;
        tick();
        chk("to_gnt",    cli_gnt, 4'b0010);
        chk("to_rd_req", rd_req,  1'b1);
        cli_req = 4'b1001;
        seen_s  = 1'b0;
        for (int i = 1; i < 64; i++) begin
            tick();
            seen_s = seen_s | (|cli_err);
            rd_gnt = (i == 1);
        end
        chk("to_no_early_err", seen_s,  1'b0);
        chk("to_rd_low",       rd_req,  1'b0);
        chk("to_busy_no_gnt",  cli_gnt, 4'b0000);
        tick();
        chk("to_err",      cli_err,   4'b0010);
        chk("to_no_valid", cli_valid, 4'b0000);
        chk("to_err_rd",   rd_req,    1'b0);
        tick();
        chk("to_err_pulse", cli_err, 4'b0000);
        chk("to_next_gnt",  cli_gnt, 4'b1000);
        chk("to_next_req",  rd_req,  1'b1);
        chk("to_next_addr", rd_addr, 28'h0F00003);
        cli_req = 4'b0000;

        // Reset two cycles after rd_gnt, while waiting for the response
        tick();
        rd_gnt = 1'b1;
        tick();
        rd_gnt = 1'b0;
        chk("rw_in_wait", rd_req, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rw_rd_req",    rd_req,    1'b0);
        chk("rw_rd_addr",   rd_addr,   28'h0);
        chk("rw_cli_gnt",   cli_gnt,   4'b0000);
        chk("rw_cli_valid", cli_valid, 4'b0000);
        chk("rw_cli_err",   cli_err,   4'b0000);
        chk("rw_stray",     stray,     1'b0);
        chk("rw_cli_data",  cli_data,  128'h0);
        rd_valid = 1'b1;
        rd_data  = JUNK;
        tick();
        rd_valid = 1'b0;
        reset    = 1'b0;
        seen_s   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen_s = seen_s | (|cli_valid) | (|cli_err);
        end
        chk("rw_no_pulse", seen_s,   1'b0);
        chk("rw_data_zero", cli_data, 128'h0);
        cli_req = 4'b1000;
        tick();
        chk("rw_gnt3",    cli_gnt, 4'b1000);
        chk("rw_rd_req3", rd_req,  1'b1);
        chk("rw_addr3",   rd_addr, 28'h0F00003);
        cli_req = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_iocntl_arb
